seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the shared seven-segment bus on the Tiny Tapeout display.
- Sequences NUM_DIGITS BCD digits onto one 7-bit segment bus, one digit-select line per digit.
- Inserts a blanking interval between digits to prevent ghosting.
- Accepts new display values through a valid/ready handshake and applies them only at frame boundaries, so a frame never shows a torn value.

---
 rtl/seg_pkg.sv | 11 +
 rtl/seg_scan_ctrl_if.sv | 9 +
 rtl/seg7_decode.sv | 9 +
 rtl/seg_scan_ctrl.sv | 116 +++++++++++
 tb/tb_seg_scan_ctrl.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_pkg;
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Active-high {g,f,e,d,c,b,a} patterns, entry 0 is digit 0
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Digit-set update handshake between a requester and the scan controller.
interface seg_scan_ctrl_if #(parameter int NUM_DIGITS = 2);
  logic                    upd_valid;
  logic                    upd_ready;
  logic [4*NUM_DIGITS-1:0] upd_digits;

  modport master (output upd_valid, output upd_digits, input upd_ready);
  modport slave  (input upd_valid, input upd_digits, output upd_ready);
endinterface

// File: rtl/seg7_decode.sv
// BCD to seven-segment decoder; non-decimal nibbles render as blank.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb seg = (bcd <= 4'd9) ? SEG_TABLE[bcd] : SEG_BLANK;
endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with blanking and frame-aligned updates.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 2,
  parameter int PRESCALE    = 4,
  parameter int DWELL_TICKS = 4,
  parameter int BLANK_TICKS = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  seg_scan_ctrl_if.slave        upd,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] sel,
  output logic                  frame_done
);
  localparam int PW   = $clog2(PRESCALE);
  localparam int TMAX = (DWELL_TICKS > BLANK_TICKS) ? DWELL_TICKS : BLANK_TICKS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int IW   = $clog2(NUM_DIGITS);

  scan_state_t                 state, state_nxt;
  logic [PW-1:0]               pcnt;
  logic [TW-1:0]               tcnt, tcnt_nxt;
  logic [IW-1:0]               idx, idx_nxt;
  logic                        tick, frame_end, boundary, xfer;
  logic [NUM_DIGITS-1:0][3:0]  pend, active;
  logic                        pend_full;
  logic [6:0]                  dec_seg, seg_nxt;
  logic [NUM_DIGITS-1:0]       sel_nxt;

  assign tick          = (state != IDLE) && (pcnt == PW'(PRESCALE - 1));
  assign upd.upd_ready = !pend_full;
  assign xfer          = upd.upd_valid && upd.upd_ready;
  // IDLE is always a safe point to swap the displayed value
  assign boundary      = frame_end || (state == IDLE);

  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    idx_nxt   = idx;
    frame_end = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
      tcnt_nxt  = '0;
      idx_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = BLANK;
          tcnt_nxt  = '0;
          idx_nxt   = '0;
        end
        BLANK: if (tick) begin
          if (tcnt == TW'(BLANK_TICKS - 1)) begin
            state_nxt = SHOW;
            tcnt_nxt  = '0;
          end else tcnt_nxt = tcnt + 1'b1;
        end
        SHOW: if (tick) begin
          if (tcnt == TW'(DWELL_TICKS - 1)) begin
            state_nxt = BLANK;
            tcnt_nxt  = '0;
            frame_end = (idx == IW'(NUM_DIGITS - 1));
            idx_nxt   = frame_end ? '0 : idx + 1'b1;
          end else tcnt_nxt = tcnt + 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs are computed from next state so they register on the same edge
  seg7_decode u_dec (.bcd(active[idx_nxt]), .seg(dec_seg));
  assign seg_nxt = (state_nxt == SHOW) ? dec_seg : SEG_BLANK;
  assign sel_nxt = (state_nxt == SHOW) ? (NUM_DIGITS'(1) << idx_nxt) : '0;

  // Resetting into BLANK matches the enable=1 case; with enable=0 the
  // next edge drops to IDLE with identical (all-off) outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= BLANK;
      pcnt       <= '0;
      tcnt       <= '0;
      idx        <= '0;
      seg        <= SEG_BLANK;
      sel        <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      tcnt       <= tcnt_nxt;
      idx        <= idx_nxt;
      seg        <= seg_nxt;
      sel        <= sel_nxt;
      frame_done <= frame_end;
      if (!enable || state == IDLE || tick) pcnt <= '0;
      else                                  pcnt <= pcnt + 1'b1;
    end
  end

  // Pending is only written while empty, so apply and capture never collide
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend      <= '0;
      pend_full <= 1'b0;
      active    <= '1;
    end else if (boundary && pend_full) begin
      active    <= pend;
      pend_full <= 1'b0;
    end else if (xfer) begin
      pend      <= upd.upd_digits;
      pend_full <= 1'b1;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl at default parameters (2 digits, 40-cycle frame).
module tb_seg_scan_ctrl;
  logic       clk = 1'b0;
  logic       reset, enable;
  logic [6:0] seg;
  logic [1:0] sel;
  logic       frame_done;
  int         chk = 0, pass = 0, cyc = 0;

  seg_scan_ctrl_if #(.NUM_DIGITS(2)) u_if ();

  seg_scan_ctrl #(.NUM_DIGITS(2), .PRESCALE(4), .DWELL_TICKS(4), .BLANK_TICKS(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .upd(u_if),
    .seg(seg), .sel(sel), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // cyc counts rising edges since reset release; sampling is on falling edges
  task automatic goto(input int k);
    while (cyc < k) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic start();
    reset = 1'b1; enable = 1'b1;
    u_if.upd_valid = 1'b0; u_if.upd_digits = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1;
    u_if.upd_valid = 1'b0; u_if.upd_digits = '0;
    @(negedge clk);
    chk++; if (seg !== 7'h00) $display("FAIL reset_seg got %h exp 00", seg); else pass++;
    chk++; if (sel !== 2'b00) $display("FAIL reset_sel got %b exp 00", sel); else pass++;
    chk++; if (frame_done !== 1'b0) $display("FAIL reset_fd got %b exp 0", frame_done); else pass++;
    chk++; if (u_if.upd_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", u_if.upd_ready); else pass++;
  endtask

  task automatic test_scan_timing();
    logic [1:0] esel;
    logic       efd;
    start();
    for (int k = 0; k <= 84; k++) begin
      goto(k);
      esel = ((k % 40) < 4) ? 2'b00 : ((k % 40) < 20) ? 2'b01 : ((k % 40) < 24) ? 2'b00 : 2'b10;
      efd  = (k > 0) && ((k % 40) == 0);
      chk++; if (sel !== esel) $display("FAIL scan_sel cyc %0d got %b exp %b", k, sel, esel); else pass++;
      chk++; if (frame_done !== efd) $display("FAIL scan_fd cyc %0d got %b exp %b", k, frame_done, efd); else pass++;
      chk++; if (seg !== 7'h00) $display("FAIL scan_seg_blank cyc %0d got %h exp 00", k, seg); else pass++;
    end
  endtask

  task automatic test_update();
    start();
    u_if.upd_digits = 8'h32; u_if.upd_valid = 1'b1;
    chk++; if (u_if.upd_ready !== 1'b1) $display("FAIL upd_ready_pre got %b exp 1", u_if.upd_ready); else pass++;
    goto(1); u_if.upd_valid = 1'b0;
    chk++; if (u_if.upd_ready !== 1'b0) $display("FAIL upd_ready_drop got %b exp 0", u_if.upd_ready); else pass++;
    goto(4);
    chk++; if (seg !== 7'h00) $display("FAIL upd_no_tear got %h exp 00", seg); else pass++;
    goto(39);
    chk++; if (u_if.upd_ready !== 1'b0) $display("FAIL upd_ready_hold got %b exp 0", u_if.upd_ready); else pass++;
    goto(40);
    chk++; if (u_if.upd_ready !== 1'b1) $display("FAIL upd_ready_rise got %b exp 1", u_if.upd_ready); else pass++;
    goto(44);
    chk++; if (sel !== 2'b01) $display("FAIL upd_d0_sel got %b exp 01", sel); else pass++;
    chk++; if (seg !== 7'h5B) $display("FAIL upd_d0_seg got %h exp 5b", seg); else pass++;
    goto(64);
    chk++; if (sel !== 2'b10) $display("FAIL upd_d1_sel got %b exp 10", sel); else pass++;
    chk++; if (seg !== 7'h4F) $display("FAIL upd_d1_seg got %h exp 4f", seg); else pass++;
  endtask

  task automatic test_back_to_back();
    start();
    u_if.upd_digits = 8'h11; u_if.upd_valid = 1'b1;
    goto(1); u_if.upd_digits = 8'h99;
    chk++; if (u_if.upd_ready !== 1'b0) $display("FAIL b2b_stall got %b exp 0", u_if.upd_ready); else pass++;
    goto(39);
    chk++; if (u_if.upd_ready !== 1'b0) $display("FAIL b2b_stall_late got %b exp 0", u_if.upd_ready); else pass++;
    goto(40);
    chk++; if (u_if.upd_ready !== 1'b1) $display("FAIL b2b_ready got %b exp 1", u_if.upd_ready); else pass++;
    goto(41); u_if.upd_valid = 1'b0;
    chk++; if (u_if.upd_ready !== 1'b0) $display("FAIL b2b_second_taken got %b exp 0", u_if.upd_ready); else pass++;
    goto(44);
    chk++; if (seg !== 7'h06) $display("FAIL b2b_n1_d0 got %h exp 06", seg); else pass++;
    goto(64);
    chk++; if (seg !== 7'h06) $display("FAIL b2b_n1_d1 got %h exp 06", seg); else pass++;
    goto(80);
    chk++; if (frame_done !== 1'b1) $display("FAIL b2b_fd got %b exp 1", frame_done); else pass++;
    goto(84);
    chk++; if (seg !== 7'h6F) $display("FAIL b2b_n2_d0 got %h exp 6f", seg); else pass++;
    goto(104);
    chk++; if (seg !== 7'h6F) $display("FAIL b2b_n2_d1 got %h exp 6f", seg); else pass++;
  endtask

  task automatic test_blank_digit();
    start();
    u_if.upd_digits = 8'hA5; u_if.upd_valid = 1'b1;
    goto(1); u_if.upd_valid = 1'b0;
    goto(44);
    chk++; if (seg !== 7'h6D) $display("FAIL nib5_seg got %h exp 6d", seg); else pass++;
    goto(64);
    chk++; if (sel !== 2'b10) $display("FAIL nibA_sel got %b exp 10", sel); else pass++;
    chk++; if (seg !== 7'h00) $display("FAIL nibA_seg got %h exp 00", seg); else pass++;
  endtask

  task automatic test_disable();
    start();
    u_if.upd_digits = 8'h32; u_if.upd_valid = 1'b1;
    goto(1); u_if.upd_valid = 1'b0;
    goto(70);
    chk++; if (seg !== 7'h4F) $display("FAIL dis_pre_seg got %h exp 4f", seg); else pass++;
    enable = 1'b0;
    goto(71);
    chk++; if (sel !== 2'b00) $display("FAIL dis_sel got %b exp 00", sel); else pass++;
    chk++; if (seg !== 7'h00) $display("FAIL dis_seg got %h exp 00", seg); else pass++;
    chk++; if (frame_done !== 1'b0) $display("FAIL dis_fd got %b exp 0", frame_done); else pass++;
    u_if.upd_digits = 8'h87; u_if.upd_valid = 1'b1;
    goto(72); u_if.upd_valid = 1'b0;
    chk++; if (u_if.upd_ready !== 1'b0) $display("FAIL dis_capture got %b exp 0", u_if.upd_ready); else pass++;
    goto(73); enable = 1'b1;
    chk++; if (u_if.upd_ready !== 1'b1) $display("FAIL dis_idle_apply got %b exp 1", u_if.upd_ready); else pass++;
    goto(77);
    chk++; if (sel !== 2'b00) $display("FAIL ren_blank got %b exp 00", sel); else pass++;
    goto(78);
    chk++; if (sel !== 2'b01) $display("FAIL ren_d0_sel got %b exp 01", sel); else pass++;
    chk++; if (seg !== 7'h07) $display("FAIL ren_d0_seg got %h exp 07", seg); else pass++;
    goto(98);
    chk++; if (seg !== 7'h7F) $display("FAIL ren_d1_seg got %h exp 7f", seg); else pass++;
  endtask

  task automatic test_reset_midframe();
    start();
    u_if.upd_digits = 8'h32; u_if.upd_valid = 1'b1;
    goto(1); u_if.upd_valid = 1'b0;
    goto(45); u_if.upd_digits = 8'h55; u_if.upd_valid = 1'b1;
    goto(46); u_if.upd_valid = 1'b0;
    chk++; if (seg !== 7'h5B) $display("FAIL rst_pre_seg got %h exp 5b", seg); else pass++;
    chk++; if (u_if.upd_ready !== 1'b0) $display("FAIL rst_pre_full got %b exp 0", u_if.upd_ready); else pass++;
    #2 reset = 1'b1;
    #1;
    chk++; if (seg !== 7'h00) $display("FAIL rst_async_seg got %h exp 00", seg); else pass++;
    chk++; if (sel !== 2'b00) $display("FAIL rst_async_sel got %b exp 00", sel); else pass++;
    chk++; if (u_if.upd_ready !== 1'b1) $display("FAIL rst_async_ready got %b exp 1", u_if.upd_ready); else pass++;
    repeat (2) @(negedge clk);
    reset = 1'b0; cyc = 0;
    goto(44);
    chk++; if (sel !== 2'b01) $display("FAIL rst_post_sel got %b exp 01", sel); else pass++;
    chk++; if (seg !== 7'h00) $display("FAIL rst_post_d0 got %h exp 00", seg); else pass++;
    goto(64);
    chk++; if (seg !== 7'h00) $display("FAIL rst_post_d1 got %h exp 00", seg); else pass++;
    goto(84);
    chk++; if (seg !== 7'h00) $display("FAIL rst_no_pending got %h exp 00", seg); else pass++;
  endtask

  initial begin
    test_reset();
    test_scan_timing();
    test_update();
    test_back_to_back();
    test_blank_digit();
    test_disable();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at cyc %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
